slave_ngsx: RTL and testbench
=============================

SLAVE_NGSX -- requirements
Module: slave_ngsx

Interface
REQ-001 Parameter BYTE_REGS, default 1, sets the number of byte registers exchanged per frame (frame length N = BYTE_REGS*8 bits).
REQ-002 iClk  input  1  SGPIO serial clock driven by the master; all block logic is clocked on its rising edge.
REQ-003 iRst_n  input  1  reset, asynchronous, active-low.
REQ-004 iLoad_n  input  1  load pulse from the master, active-low, one iClk period wide, coincident with the last (LSB) bit of the master frame.
REQ-005 iSData  input  1  serial data from the master, MSB first.
REQ-006 oSData  output  1  serial data to the master, MSB first.
REQ-007 iPData  input  N  parallel data from internal logic, serialized to the master.
REQ-008 oPData  output  N  last complete frame received from the master.
REQ-009 oFrameValid  output  1  one-cycle pulse when oPData is updated.
REQ-010 oFrameErr  output  1  one-cycle pulse on a framing error.
REQ-011 oLocked  output  1  level, high while the frame-lock FSM is in LOCKED.

Function
REQ-012 iLoad_n and iSData SHALL be sampled on every iClk rising edge, mid-bit relative to master falling-edge launch.
REQ-013 The receive shift register SHALL shift left by one on every rising edge, with iSData entering at bit 0.
REQ-014 The capture value for oPData SHALL be the shifted vector that includes the bit sampled on the same edge as iLoad_n==0.
REQ-015 On an edge sampling iLoad_n==0, the transmit shift register SHALL load iPData; on all other edges it SHALL shift left by one and fill with 0.
REQ-016 oSData SHALL equal the transmit register MSB, so iPData[N-1] is presented in the cycle immediately after the load edge, ahead of the master's next falling-edge sample.
REQ-017 Transmit loading SHALL occur on every sampled load regardless of lock state.
REQ-018 Bit counter width SHALL be clog2(N)+1.
REQ-019 The bit counter SHALL clear to 0 on a sampled load and otherwise increment, saturating at N-1.
REQ-020 A load is "expected" when it is sampled with counter == N-1, i.e. exactly N edges after the previous load.
REQ-021 FSM states are SEARCH, CHECK and LOCKED.
REQ-022 SEARCH: any load -> CHECK; no outputs change.
REQ-023 CHECK: expected load -> LOCKED, with oPData updated and oFrameValid pulsed on the same edge.
REQ-024 CHECK: early load (counter < N-1) -> stay in CHECK (counter restarts) and pulse oFrameErr.
REQ-025 CHECK or LOCKED: counter == N-1 with iLoad_n==1 (missing load) -> SEARCH and pulse oFrameErr.
REQ-026 LOCKED: expected load -> update oPData and pulse oFrameValid.
REQ-027 LOCKED: early load -> CHECK and pulse oFrameErr; oPData is not updated.
REQ-028 oPData SHALL hold its value between updates and SHALL never be updated outside CHECK->LOCKED or LOCKED.
REQ-029 Load held low for consecutive edges SHALL count as an early load on the second edge.
REQ-030 Output latency: oPData and oFrameValid are registered and valid in the cycle after the load edge.

Reset
REQ-031 While iRst_n==0: oSData=0, oPData=0, oFrameValid=0, oFrameErr=0, oLocked=0, both shift registers=0, counter=0, FSM=SEARCH.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately; the first frame after release SHALL NOT be published (at least two loads are required before the first oFrameValid).
REQ-033 Reset SHALL dominate a simultaneous iLoad_n==0.

Structure
REQ-034 State encodings and N, MAX_CNT and CNT_SIZE SHALL be localparams; the clog2 function SHALL come from the shared ngsx include used by the master.
REQ-035 The counter and lock FSM SHALL be one sub-module, ngsx_frame_sync (outputs: load_ok, frame_err, locked); shift registers stay in the top level.

Verification
REQ-036 BYTE_REGS=2, master sends 0xA55A then 0x3C3C with a load every 16 clocks -> no oFrameValid on the first load, oFrameValid with oPData=0xA55A on the second, oPData=0x3C3C on the third, oLocked=1.
REQ-037 iPData=0xC3F0 held, loads every 16 clocks -> oSData bit stream after each load is 1100001111110000, then 0 until the next load.
REQ-038 Locked, then a load at count 9 -> oFrameErr pulse, oLocked=0, oPData unchanged; re-locks after the next correctly spaced load.
REQ-039 Locked, then load withheld for 20 clocks -> oFrameErr at count 15, FSM=SEARCH; two further correctly spaced loads are required to re-lock.
REQ-040 iRst_n pulsed low at bit 7 of a frame -> all outputs 0 asynchronously, with no oFrameValid until the second load after release.
REQ-041 BYTE_REGS=1, back-to-back loads every 8 clocks with a master loopback model -> master oPData equals slave iPData, and slave oPData equals master iPData, every frame.

Source files
------------

// File: rtl/slave_ngsx_pkg.sv
`default_nettype none
// =============================================================================
// Module   : slave_ngsx_pkg
// Purpose  : Shared constants, types and helpers for the NGSX SGPIO slave.
//            Holds the frame-lock FSM state encodings, the per-edge decision
//            record used by the frame synchroniser, and the clog2 helper that
//            is also used on the master side to size bit counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// =============================================================================
package slave_ngsx_pkg;

   // Bits carried by one byte register of the frame.
   localparam int BITS_PER_REG = 8;

   // Frame-lock FSM state encodings.
   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // Outcome of one sampled edge: next FSM state plus the two event strobes.
   typedef struct packed {
      logic [1:0] state;
      logic       load_ok;
      logic       frame_err;
   } sync_step_t;

   // Ceiling log2, usable in constant expressions. ngsx_clog2(1) = 0.
   function automatic int ngsx_clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/slave_ngsx_if.sv
`default_nettype none
// =============================================================================
// Module   : slave_ngsx_if
// Purpose  : Bundle of the SGPIO serial link and the parallel frame ports of
//            the NGSX slave.
// Ports    : (interface signals)
//            iLoad_n     - master load pulse, active-low, on the frame LSB
//            iSData      - serial data master -> slave, MSB first
//            oSData      - serial data slave -> master, MSB first
//            iPData      - parallel data to be serialised to the master
//            oPData      - last complete frame received from the master
//            oFrameValid - one-cycle pulse when oPData updates
//            oFrameErr   - one-cycle pulse on a framing error
//            oLocked     - high while the frame-lock FSM is LOCKED
//            Modport master drives the link/parallel inputs, modport slave
//            drives the outputs.
// Revision : 1.0 - initial release
// =============================================================================
interface slave_ngsx_if
   import slave_ngsx_pkg::*;
#(
   parameter int BYTE_REGS = 1
);

   localparam int N = BYTE_REGS * BITS_PER_REG;

   logic           iLoad_n;
   logic           iSData;
   logic           oSData;
   logic [N-1:0]   iPData;
   logic [N-1:0]   oPData;
   logic           oFrameValid;
   logic           oFrameErr;
   logic           oLocked;

   modport master (
      output iLoad_n,
      output iSData,
      output iPData,
      input  oSData,
      input  oPData,
      input  oFrameValid,
      input  oFrameErr,
      input  oLocked
   );

   modport slave (
      input  iLoad_n,
      input  iSData,
      input  iPData,
      output oSData,
      output oPData,
      output oFrameValid,
      output oFrameErr,
      output oLocked
   );

endinterface
`default_nettype wire

// File: rtl/ngsx_frame_sync.sv
`default_nettype none
// =============================================================================
// Module   : ngsx_frame_sync
// Purpose  : Bit counter and frame-lock FSM for the NGSX slave. Decides on
//            every edge whether a sampled load is the expected one (exactly
//            N edges after the previous load), early, or missing.
// Ports    : clk       - SGPIO clock, rising edge
//            rst_n     - asynchronous active-low reset
//            load_n    - sampled load pulse, active-low
//            load_ok   - this edge carries an expected load in CHECK/LOCKED;
//                        the frame on this edge must be published
//            frame_err - this edge detects an early or missing load
//            locked    - FSM currently in LOCKED
// Revision : 1.0 - initial release
// =============================================================================
module ngsx_frame_sync
   import slave_ngsx_pkg::*;
#(
   parameter int N = 8
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load_n,
   output logic load_ok,
   output logic frame_err,
   output logic locked
);

   localparam int                  CNT_SIZE = ngsx_clog2(N) + 1;
   localparam logic [CNT_SIZE-1:0] MAX_CNT  = CNT_SIZE'(N - 1);

   logic [CNT_SIZE-1:0] r_cnt;
   logic [1:0]          r_state;
   logic                w_load;
   logic                w_at_max;
   sync_step_t          w_step;

   assign w_load   = ~load_n;
   assign w_at_max = (r_cnt == MAX_CNT);

   // Per-edge transition decision. A missing load is recognised on the edge
   // where the counter already sits at N-1 and no load is sampled.
   always_comb begin
      w_step.state     = r_state;
      w_step.load_ok   = 1'b0;
      w_step.frame_err = 1'b0;
      case (r_state)
         ST_SEARCH: begin
            if (w_load) begin
               w_step.state = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_load) begin
               if (w_at_max) begin
                  w_step.state   = ST_LOCKED;
                  w_step.load_ok = 1'b1;
               end else begin
                  w_step.frame_err = 1'b1;
               end
            end else if (w_at_max) begin
               w_step.state     = ST_SEARCH;
               w_step.frame_err = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_load) begin
               if (w_at_max) begin
                  w_step.load_ok = 1'b1;
               end else begin
                  w_step.state     = ST_CHECK;
                  w_step.frame_err = 1'b1;
               end
            end else if (w_at_max) begin
               w_step.state     = ST_SEARCH;
               w_step.frame_err = 1'b1;
            end
         end
         default: begin
            w_step.state = ST_SEARCH;
         end
      endcase
   end

   // Counter restarts on every load and saturates so that a long gap in
   // SEARCH never wraps into a false "expected" position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_state <= ST_SEARCH;
      end else begin
         if (w_load) begin
            r_cnt <= '0;
         end else if (!w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_state <= w_step.state;
      end
   end

   assign load_ok   = w_step.load_ok;
   assign frame_err = w_step.frame_err;
   assign locked    = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: rtl/slave_ngsx.sv
`default_nettype none
// =============================================================================
// Module   : slave_ngsx
// Purpose  : NGSX SGPIO slave. Deserialises frames from the master into
//            oPData once frame lock is established and serialises iPData back
//            to the master, reloading on every sampled load.
// Ports    : iClk   - SGPIO clock from the master, rising edge
//            iRst_n - asynchronous active-low reset
//            bus    - slave_ngsx_if.slave (serial link, parallel data,
//                     frame valid/error pulses, lock level)
// Revision : 1.0 - initial release
// =============================================================================
module slave_ngsx
   import slave_ngsx_pkg::*;
#(
   parameter int BYTE_REGS = 1
)(
   input  logic          iClk,
   input  logic          iRst_n,
   slave_ngsx_if.slave   bus
);

   localparam int N = BYTE_REGS * BITS_PER_REG;

   // Only the newest N-1 received bits are stored: the published frame is
   // always these plus the bit sampled on the load edge itself, so the
   // oldest bit of a full-width register would never be observed.
   logic [N-2:0] r_rx;
   logic [N-1:0] w_rx_next;
   logic [N-1:0] r_tx;
   logic [N-1:0] r_pdata;
   logic         r_valid;
   logic         r_err;
   logic         w_load_ok;
   logic         w_frame_err;
   logic         w_locked;

   assign w_rx_next = {r_rx, bus.iSData};

   ngsx_frame_sync #(
      .N         (N)
   ) u_frame_sync (
      .clk       (iClk),
      .rst_n     (iRst_n),
      .load_n    (bus.iLoad_n),
      .load_ok   (w_load_ok),
      .frame_err (w_frame_err),
      .locked    (w_locked)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_rx    <= '0;
         r_tx    <= '0;
         r_pdata <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_rx <= w_rx_next[N-2:0];
         // Transmit reloads on every sampled load, independent of lock, so
         // the master always sees fresh data in the following frame.
         if (!bus.iLoad_n) begin
            r_tx <= bus.iPData;
         end else begin
            r_tx <= {r_tx[N-2:0], 1'b0};
         end
         if (w_load_ok) begin
            r_pdata <= w_rx_next;
         end
         r_valid <= w_load_ok;
         r_err   <= w_frame_err;
      end
   end

   assign bus.oSData      = r_tx[N-1];
   assign bus.oPData      = r_pdata;
   assign bus.oFrameValid = r_valid;
   assign bus.oFrameErr   = r_err;
   assign bus.oLocked     = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_slave_ngsx.sv
`default_nettype none
// =============================================================================
// Module   : tb_slave_ngsx
// Purpose  : Directed self-checking bench for slave_ngsx. A 2-byte instance
//            covers lock acquisition, serial output, early/missing/held loads
//            and mid-frame reset; a 1-byte instance runs against a master
//            loopback model.
// Ports    : none
// Revision : 1.0 - initial release
// =============================================================================
module tb_slave_ngsx;

   logic clk = 1'b0;
   logic rst_n;

   int vectors     = 0;
   int miscompares = 0;
   int stray       = 0;

   logic so_a;
   logic so_b;

   slave_ngsx_if #(.BYTE_REGS(2)) bus_a();
   slave_ngsx_if #(.BYTE_REGS(1)) bus_b();

   slave_ngsx #(.BYTE_REGS(2)) dut_a (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus_a)
   );

   slave_ngsx #(.BYTE_REGS(1)) dut_b (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors = vectors + 1;
      if (got !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Master launches on the falling edge; oSData is sampled there first.
   task automatic bit_a(input logic ld_n, input logic sd);
      @(negedge clk);
      so_a          = bus_a.oSData;
      bus_a.iLoad_n = ld_n;
      bus_a.iSData  = sd;
      @(posedge clk);
      #1;
   endtask

   task automatic bit_b(input logic ld_n, input logic sd);
      @(negedge clk);
      so_b          = bus_b.oSData;
      bus_b.iLoad_n = ld_n;
      bus_b.iSData  = sd;
      @(posedge clk);
      #1;
   endtask

   task automatic frame_a(input logic [15:0] data, input int nbits, input logic do_load,
                          output logic [15:0] ser);
      ser = '0;
      for (int i = 0; i < nbits; i++) begin
         bit_a((do_load && (i == nbits - 1)) ? 1'b0 : 1'b1, data[15 - i]);
         ser = {ser[14:0], so_a};
         if ((i != nbits - 1) && (bus_a.oFrameValid || bus_a.oFrameErr)) begin
            stray = stray + 1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] ser;
      logic [31:0] ser32;
      logic [7:0]  m_rx;
      logic [7:0]  md [5];
      logic [7:0]  sd [5];
      int          err_at;
      int          err_cnt;
      logic        lock16;

      md = '{8'h96, 8'h3C, 8'hF0, 8'h01, 8'hFF};
      sd = '{8'h5A, 8'hC3, 8'h0F, 8'h80, 8'h7E};

      rst_n         = 1'b0;
      bus_a.iLoad_n = 1'b1;
      bus_a.iSData  = 1'b0;
      bus_a.iPData  = 16'hC3F0;
      bus_b.iLoad_n = 1'b1;
      bus_b.iSData  = 1'b0;
      bus_b.iPData  = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_sdata",  32'(bus_a.oSData),      0);
      check_val("rst_pdata",  32'(bus_a.oPData),      0);
      check_val("rst_valid",  32'(bus_a.oFrameValid), 0);
      check_val("rst_err",    32'(bus_a.oFrameErr),   0);
      check_val("rst_locked", 32'(bus_a.oLocked),     0);

      // Load during reset must not reach the transmit register
      bit_a(1'b0, 1'b1);
      check_val("rst_dom_sdata", 32'(bus_a.oSData), 0);
      check_val("rst_dom_pdata", 32'(bus_a.oPData), 0);
      rst_n = 1'b1;

      // Lock acquisition: first load not published
      frame_a(16'h1234, 16, 1'b1, ser);
      check_val("f0_valid",  32'(bus_a.oFrameValid), 0);
      check_val("f0_locked", 32'(bus_a.oLocked),     0);
      frame_a(16'hA55A, 16, 1'b1, ser);
      check_val("f1_valid",  32'(bus_a.oFrameValid), 1);
      check_val("f1_pdata",  32'(bus_a.oPData),      32'hA55A);
      check_val("f1_locked", 32'(bus_a.oLocked),     1);
      check_val("f1_sdata",  32'(ser),               32'hC3F0);
      frame_a(16'h3C3C, 16, 1'b1, ser);
      check_val("f2_valid",  32'(bus_a.oFrameValid), 1);
      check_val("f2_pdata",  32'(bus_a.oPData),      32'h3C3C);
      check_val("f2_sdata",  32'(ser),               32'hC3F0);

      // Early load at count 9
      frame_a(16'hFFFF, 10, 1'b1, ser);
      check_val("early_err",    32'(bus_a.oFrameErr),   1);
      check_val("early_valid",  32'(bus_a.oFrameValid), 0);
      check_val("early_locked", 32'(bus_a.oLocked),     0);
      check_val("early_pdata",  32'(bus_a.oPData),      32'h3C3C);
      frame_a(16'h5AA5, 16, 1'b1, ser);
      check_val("relock_valid",  32'(bus_a.oFrameValid), 1);
      check_val("relock_pdata",  32'(bus_a.oPData),      32'h5AA5);
      check_val("relock_locked", 32'(bus_a.oLocked),     1);
      check_val("relock_sdata",  32'(ser),               32'hC3F0);

      // Load withheld for 20 clocks
      err_at  = 0;
      err_cnt = 0;
      ser32   = '0;
      lock16  = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         bit_a(1'b1, 1'b0);
         ser32 = {ser32[30:0], so_a};
         if (bus_a.oFrameErr) begin
            err_cnt = err_cnt + 1;
            err_at  = e;
         end
         if (bus_a.oFrameValid) begin
            stray = stray + 1;
         end
         if (e == 16) begin
            lock16 = bus_a.oLocked;
         end
      end
      check_val("miss_err_edge", 32'(err_at),  16);
      check_val("miss_err_cnt",  32'(err_cnt), 1);
      check_val("miss_locked",   32'(lock16),  0);
      check_val("miss_sdata",    32'(ser32[19:0]), 32'hC3F00);
      frame_a(16'h1111, 16, 1'b1, ser);
      check_val("miss_l1_valid",  32'(bus_a.oFrameValid), 0);
      check_val("miss_l1_locked", 32'(bus_a.oLocked),     0);
      frame_a(16'h2222, 16, 1'b1, ser);
      check_val("miss_l2_valid",  32'(bus_a.oFrameValid), 1);
      check_val("miss_l2_pdata",  32'(bus_a.oPData),      32'h2222);
      check_val("miss_l2_locked", 32'(bus_a.oLocked),     1);

      // Load held low on two consecutive edges
      frame_a(16'h7777, 16, 1'b1, ser);
      check_val("held_pdata1", 32'(bus_a.oPData), 32'h7777);
      bit_a(1'b0, 1'b0);
      check_val("held_err",    32'(bus_a.oFrameErr),   1);
      check_val("held_valid",  32'(bus_a.oFrameValid), 0);
      check_val("held_locked", 32'(bus_a.oLocked),     0);
      check_val("held_pdata2", 32'(bus_a.oPData),      32'h7777);
      frame_a(16'h4444, 16, 1'b1, ser);
      check_val("held_relock_pdata", 32'(bus_a.oPData), 32'h4444);
      check_val("held_relock_sdata", 32'(ser),          32'hC3F0);

      // Asynchronous reset at bit 7 of a frame
      frame_a(16'hFE00, 7, 1'b0, ser);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_pdata",  32'(bus_a.oPData),      0);
      check_val("arst_sdata",  32'(bus_a.oSData),      0);
      check_val("arst_locked", 32'(bus_a.oLocked),     0);
      check_val("arst_valid",  32'(bus_a.oFrameValid), 0);
      check_val("arst_err",    32'(bus_a.oFrameErr),   0);
      bit_a(1'b0, 1'b1);
      check_val("arst_dom_sdata", 32'(bus_a.oSData), 0);
      rst_n = 1'b1;
      frame_a(16'h0F0F, 16, 1'b1, ser);
      check_val("arst_l1_valid", 32'(bus_a.oFrameValid), 0);
      check_val("arst_l1_pdata", 32'(bus_a.oPData),      0);
      frame_a(16'hBEEF, 16, 1'b1, ser);
      check_val("arst_l2_valid",  32'(bus_a.oFrameValid), 1);
      check_val("arst_l2_pdata",  32'(bus_a.oPData),      32'hBEEF);
      check_val("arst_l2_locked", 32'(bus_a.oLocked),     1);

      // 1-byte loopback with master model
      for (int f = 0; f < 5; f++) begin
         bus_b.iPData = sd[f];
         m_rx = '0;
         for (int b = 0; b < 8; b++) begin
            bit_b((b == 7) ? 1'b0 : 1'b1, md[f][7 - b]);
            m_rx = {m_rx[6:0], so_b};
         end
         if (f == 0) begin
            check_val("lb_mrx_first", 32'(m_rx), 0);
            check_val("lb_valid_first", 32'(bus_b.oFrameValid), 0);
         end else begin
            check_val("lb_mrx",   32'(m_rx),              32'(sd[f - 1]));
            check_val("lb_pdata", 32'(bus_b.oPData),      32'(md[f]));
            check_val("lb_valid", 32'(bus_b.oFrameValid), 1);
         end
      end

      check_val("stray_pulses", 32'(stray), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
